// File: rtl/dispense_pkg.sv
// Shared constants for the dispense order sequencer: error codes, parser and
// dispatcher state encodings, default header byte and status byte prefixes.
package dispense_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CSUM = 3'd1;
  localparam logic [2:0] ERR_BAD_AMT  = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_EMPTY    = 3'd5;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_AMT  = 2'd1;
  localparam logic [1:0] P_CSUM = 2'd2;

  localparam logic [1:0] D_IDLE   = 2'd0;
  localparam logic [1:0] D_SETTLE = 2'd1;
  localparam logic [1:0] D_WAIT   = 2'd2;

  localparam logic [7:0] STAT_ACCEPT = 8'h80;
  localparam logic [7:0] STAT_ERROR  = 8'h40;

  // An amount byte is out of range when any bit above the amount field is set.
  function automatic logic amt_out_of_range(input logic [7:0] b, input int amt_w);
    return (b >> amt_w) != 8'd0;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order queue. Push into a full queue and pop from an empty queue
// are ignored; a simultaneous push and pop leaves the level unchanged.
module order_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/flops cheaply.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dispense_order_sequencer.sv
// Dispense order sequencer: parses framed, checksummed order packets from the
// UART byte stream, queues accepted orders and launches each to the dispense
// controllers once all of them are idle.
// Optional feature macro: STATUS_TX_EN adds a status byte stream (tx_*).
module dispense_order_sequencer
  import dispense_pkg::*;
#(
  parameter int         NUM_CH      = 5,
  parameter int         AMT_W       = 3,
  parameter int         DEPTH       = 4,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] HDR         = HDR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic [NUM_CH-1:0]           ch_busy,
  output logic                        ch_start,
  output logic [NUM_CH*AMT_W-1:0]     ch_count,
  output logic [$clog2(DEPTH):0]      q_level,
  output logic                        err_valid,
  output logic [2:0]                  err_code
`ifdef STATUS_TX_EN
  ,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
`endif
);

  localparam int OW = NUM_CH * AMT_W;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]       p_state;
  logic [IW-1:0]    idx;
  logic [7:0]       run_xor;
  logic             bad_amt;
  logic [AMT_W-1:0] amt [NUM_CH];
  logic [CW-1:0]    tmo_cnt;

  logic [1:0]       d_state;

  logic [OW-1:0]    order_word;
  logic [OW-1:0]    fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             csum_evt;
  logic             tmo_evt;
  logic             err_evt;
  logic [2:0]       pkt_err;
  logic [2:0]       err_next;
  logic             push;
  logic             launch;

  // Pack the stored per-channel amounts into one order word, channel 0 lowest.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    order_word = '0;
    for (int i = 0; i < NUM_CH; i++) order_word[i*AMT_W +: AMT_W] = amt[i];
  end

  assign csum_evt = rx_valid && (p_state == P_CSUM);
  assign tmo_evt  = !rx_valid && (p_state != P_IDLE) && (tmo_cnt == TMO_LAST);

  // Classify the packet at the checksum byte, in priority order.
  always_comb begin
    pkt_err = ERR_NONE;
    if (csum_evt) begin
      if (run_xor != rx_data)     pkt_err = ERR_BAD_CSUM;
      else if (bad_amt)           pkt_err = ERR_BAD_AMT;
      else if (order_word == '0)  pkt_err = ERR_EMPTY;
      else if (fifo_full)         pkt_err = ERR_OVERFLOW;
    end
  end

  assign push     = csum_evt && (pkt_err == ERR_NONE);
  assign err_evt  = (csum_evt && (pkt_err != ERR_NONE)) || tmo_evt;
  assign err_next = tmo_evt ? ERR_TIMEOUT : pkt_err;

  // Packet parser, inter-byte timeout and error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_IDLE;
      idx       <= '0;
      run_xor   <= '0;
      bad_amt   <= 1'b0;
      tmo_cnt   <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      for (int i = 0; i < NUM_CH; i++) amt[i] <= '0;
    end else begin
      if (rx_valid)                tmo_cnt <= '0;
      else if (tmo_evt)            tmo_cnt <= '0;
      else if (p_state != P_IDLE)  tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_evt) begin
        p_state <= P_IDLE;
      end else if (rx_valid) begin
        case (p_state)
          P_IDLE: begin
            if (rx_data == HDR) begin
              p_state <= P_AMT;
              idx     <= '0;
              run_xor <= '0;
              bad_amt <= 1'b0;
            end
          end
          P_AMT: begin
            amt[idx] <= rx_data[AMT_W-1:0];
            run_xor  <= run_xor ^ rx_data;
            if (amt_out_of_range(rx_data, AMT_W)) bad_amt <= 1'b1;
            if (idx == IDX_LAST) p_state <= P_CSUM;
            else                 idx     <= idx + 1'b1;
          end
          default: p_state <= P_IDLE;
        endcase
      end

      err_valid <= err_evt;
      if (err_evt) err_code <= err_next;
    end
  end

  order_fifo #(
    .WIDTH (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (order_word),
    .pop     (launch),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (q_level)
  );

  assign launch = (d_state == D_IDLE) && !fifo_empty && (ch_busy == '0);

  // Dispatcher: launch the queue head, give controllers a cycle to raise busy,
  // then wait for all of them to drop busy again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state  <= D_IDLE;
      ch_start <= 1'b0;
      ch_count <= '0;
    end else begin
      ch_start <= launch;
      case (d_state)
        D_IDLE: begin
          if (launch) begin
            ch_count <= fifo_rd;
            d_state  <= D_SETTLE;
          end
        end
        D_SETTLE: d_state <= D_WAIT;
        D_WAIT:   if (ch_busy == '0) d_state <= D_IDLE;
        default:  d_state <= D_IDLE;
      endcase
    end
  end

`ifdef STATUS_TX_EN
  logic [$clog2(DEPTH):0] level_after;
  assign level_after = q_level + 1'b1 - {{$clog2(DEPTH){1'b0}}, launch};

  // One-entry status register; a newer outcome overwrites a pending byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (push) begin
      tx_data  <= STAT_ACCEPT | 8'(level_after);
      tx_valid <= 1'b1;
    end else if (err_evt) begin
      tx_data  <= STAT_ERROR | {5'd0, err_next};
      tx_valid <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/dispense_order_sequencer.md
Name: dispense_order_sequencer

Overview:
Parametrised successor to the fixed 5-channel, two-byte command manager. It takes a framed, checksummed byte stream from the UART receiver and validates each order packet. Accepted orders go into a DEPTH-entry queue instead of being dropped while the system is busy. Each queued order is launched to NUM_CH parallel dispense controllers only once all of them are idle.

Parameters:
- NUM_CH, 5: number of dispense channels (1..8)
- AMT_W, 3: per-channel amount width in bits (1..7)
- DEPTH, 4: order queue depth (power of two, >= 2)
- TIMEOUT_CYC, 500000: inter-byte timeout in clk cycles (10 ms at 50 MHz)
- HDR, 8'hA5: packet header byte

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte from UART_RX
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- ch_busy  in  NUM_CH  busy flags from the dispense controllers
- ch_start  out  1  one-cycle launch pulse to all controllers
- ch_count  out  NUM_CH*AMT_W  launched amounts; channel i at [i*AMT_W +: AMT_W]
- q_level  out  $clog2(DEPTH)+1  orders currently queued
- err_valid  out  1  one-cycle error strobe
- err_code  out  3  error code; valid while err_valid is high
- tx_data / tx_valid / tx_ready  out/out/in  8/1/1  status byte stream; present only with STATUS_TX_EN

Behaviour:
- Reset: parser in P_IDLE, dispatcher in D_IDLE, queue empty, timeout counter 0. All outputs are 0: ch_start, ch_count, q_level, err_valid, err_code, tx_valid, tx_data.
- A reset mid-packet or mid-dispense discards all state; no pulse is emitted on exit from reset.
- Packet format: HDR, NUM_CH amount bytes (channel 0 first), then checksum byte = XOR of the amount bytes.
- Parser FSM:
  - P_IDLE: bytes other than HDR are ignored silently. HDR moves to P_AMT with the index cleared and the running XOR cleared.
  - P_AMT: each byte is stored and XORed into the running checksum.
    - If bits [7:AMT_W] are nonzero, flag BAD_AMT. Remaining bytes are still consumed and the error is reported at the checksum byte.
    - HDR inside a packet is treated as data.
    - After NUM_CH bytes, go to P_CSUM.
  - P_CSUM: return to P_IDLE. Outcomes are checked in priority order:
    1. Checksum mismatch: err BAD_CSUM.
    2. Otherwise, a BAD_AMT flag: err BAD_AMT.
    3. Otherwise, all amounts zero: err EMPTY, order not queued.
    4. Otherwise, queue full: err OVERFLOW, order dropped.
    5. Otherwise, push the order; the push is visible in q_level the next cycle.
- Timeout: the counter clears on every rx_valid and counts only outside P_IDLE. On reaching TIMEOUT_CYC, the parser returns to P_IDLE and emits err TIMEOUT.
- Error codes: 1 BAD_CSUM, 2 BAD_AMT, 3 OVERFLOW, 4 TIMEOUT, 5 EMPTY. err_valid is high for exactly one cycle per error.
- Dispatcher FSM:
  - D_IDLE: when the queue is non-empty and ch_busy == 0, register the head into ch_count, pulse ch_start for one cycle, pop, and go to D_SETTLE.
    - Earliest launch is 1 cycle after the push cycle.
  - D_SETTLE: held for one cycle so the controllers can raise busy. Then go to D_WAIT.
  - D_WAIT: stay until ch_busy == 0, then go to D_IDLE.
    - Back-to-back orders are therefore launched at least 3 cycles apart.
- ch_count holds its value until the next launch.
- Simultaneous push and pop: both take effect and q_level is unchanged.
- "Full" is evaluated before the same-cycle pop, so a push into a full queue is dropped even if a pop happens in that cycle.

Optional Feature:
STATUS_TX_EN
- Defined: one status byte is produced per packet outcome.
  - Accept: 8'h80 | q_level after the push.
  - Error: 8'h40 | err_code.
  - The byte is held in a one-entry register, with tx_valid asserted until tx_ready is seen.
  - A newer status arriving while the register is still pending overwrites it.
- Undefined: the tx ports and the status logic are absent.

Decomposition:
- Package dispense_pkg: error code constants, parser state encodings (P_IDLE/P_AMT/P_CSUM), dispatcher state encodings (D_IDLE/D_SETTLE/D_WAIT), HDR default, status prefix constants.
- Sub-module order_fifo: synchronous FIFO, width NUM_CH*AMT_W, depth DEPTH, with push/pop/full/empty/level.

Test Plan:
- NUM_CH=5, no errors: bytes A5 01 02 00 03 01 01 with ch_busy=0 -> ch_start pulses once, ch_count = 15'h1611, no err_valid.
- Same packet with checksum byte 00 -> err_valid with err_code 1, no ch_start, q_level stays 0.
- Amount byte 09 at channel 2 -> err_code 2 reported at the checksum byte; an amounts-all-zero packet A5 00 00 00 00 00 00 -> err_code 5.
- Hold ch_busy=1 and send 5 valid packets (DEPTH=4) -> q_level reaches 4, 5th packet gives err_code 3. Release busy -> 4 ch_start pulses, each launched only after ch_busy returns to 0.
- Send A5 01, then stall TIMEOUT_CYC cycles -> err_code 4. A following full valid packet is accepted.
- Assert rst_n=0 mid-D_WAIT with 2 orders queued -> all outputs 0 and q_level 0. No ch_start after release.
